dm_responder: RTL

Multi-cycle data-memory responder: the memory-side end of the CPU's load/store interface. It accepts one request at a time over a req/ack handshake and waits a parameterised number of cycles. It then performs a word, half or byte access on an internal little-endian word array and returns merged, extended read data with a one-cycle ack. It replaces the combinational DM in the upcoming multi-cycle/stall-capable datapath.

---
 rtl/dm_responder_if.sv | 25 ++
 rtl/dm_responder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/dm_responder_if.sv
// Load/store request/response bundle between the CPU (master) and the data memory (slave).
// req is held by the master until ack; req, we, addr, wdata, mode, sext, pc are sampled only while the slave is idle.
interface dm_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mode;
    logic        sext;
    logic [31:0] pc;
    logic        busy;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, mode, sext, pc,
        input  busy, ack, err, rdata
    );

    modport slave (
        input  req, we, addr, wdata, mode, sext, pc,
        output busy, ack, err, rdata
    );
endinterface

// File: rtl/dm_responder.sv
// Multi-cycle data memory: accepts one load/store, waits WAIT cycles, then performs a
// little-endian word/half/byte access and returns extended read data with a one-cycle ack.
module dm_responder #(
    parameter int DEPTH_WORDS = 3072,
    parameter int WAIT        = 2
) (
    input  logic          clk,
    input  logic          reset,
    dm_responder_if.slave bus,
    output logic [1:0]    dbg_state
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] M_WORD = 2'd0;
    localparam logic [1:0] M_HALF = 2'd1;
    localparam logic [1:0] M_BYTE = 2'd2;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          we_q, sext_q;
    logic [31:0]   addr_q, wdata_q, pc_q;
    logic [1:0]    mode_q;
    logic          err_q;
    logic [31:0]   rdata_q;

    logic          exec;
    logic          cur_we, cur_sext;
    logic [31:0]   cur_addr, cur_wdata, cur_pc;
    logic [1:0]    cur_mode;
    logic          acc_err;
    logic [IW-1:0] idx;
    logic [31:0]   old_word, merged, lane, load_val;

    // With no wait states the access runs on the accepting edge, straight from the bus.
    always_comb begin
        cur_we    = (state == S_IDLE) ? bus.we    : we_q;
        cur_addr  = (state == S_IDLE) ? bus.addr  : addr_q;
        cur_wdata = (state == S_IDLE) ? bus.wdata : wdata_q;
        cur_mode  = (state == S_IDLE) ? bus.mode  : mode_q;
        cur_sext  = (state == S_IDLE) ? bus.sext  : sext_q;
        cur_pc    = (state == S_IDLE) ? bus.pc    : pc_q;
        if (WAIT == 0) exec = (state == S_IDLE) && bus.req;
        else           exec = (state == S_WAIT) && (cnt == '0);
    end

    always_comb begin
        acc_err = (cur_mode == 2'b11)
               || ((cur_mode == M_HALF) && cur_addr[0])
               || ((cur_mode == M_WORD) && (cur_addr[1:0] != 2'b00))
               || (cur_addr >= 32'(4 * DEPTH_WORDS));
        idx      = cur_addr[IW+1:2];
        old_word = acc_err ? 32'h0 : mem[idx];
        merged   = old_word;
        lane     = old_word >> {cur_addr[1:0], 3'b000};
        load_val = old_word;
        case (cur_mode)
            M_HALF: begin
                merged[{cur_addr[1], 4'b0000} +: 16] = cur_wdata[15:0];
                load_val = {{16{cur_sext & lane[15]}}, lane[15:0]};
            end
            M_BYTE: begin
                merged[{cur_addr[1:0], 3'b000} +: 8] = cur_wdata[7:0];
                load_val = {{24{cur_sext & lane[7]}}, lane[7:0]};
            end
            default: begin
                merged   = cur_wdata;
                load_val = old_word;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            mode_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.req) begin
                    we_q    <= bus.we;
                    addr_q  <= bus.addr;
                    wdata_q <= bus.wdata;
                    mode_q  <= bus.mode;
                    sext_q  <= bus.sext;
                    pc_q    <= bus.pc;
                    if (WAIT == 0) begin
                        state <= S_RESP;
                    end else begin
                        state <= S_WAIT;
                        cnt   <= (WAIT > 0) ? CW'(WAIT - 1) : '0;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) state <= S_RESP;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
            if (exec) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || cur_we) ? 32'h0 : load_val;
                if (!acc_err && cur_we) mem[idx] <= merged;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset && exec && !acc_err && cur_we)
            $display("@%h: *%h <= %h", cur_pc, {cur_addr[31:2], 2'b00}, merged);
    end
`endif

    assign bus.busy  = (state != S_IDLE);
    assign bus.ack   = (state == S_RESP);
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign dbg_state = state;
endmodule
